// File: rtl/synth_pkg.sv
// Shared widths, FSM state encoding and per-voice record for the voice allocator.
package synth_pkg;

  localparam int unsigned NOTE_W   = 4;
  localparam int unsigned OCT_W    = 3;
  localparam int unsigned AGE_W    = 4;
  localparam int unsigned NOTE_MAX = 11;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StCommit,
    StDone
  } alloc_state_e;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [OCT_W-1:0]  octave;
    logic              gate;
    logic [AGE_W-1:0]  age;
  } voice_t;

  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] age);
    return (&age) ? age : age + AGE_W'(1);
  endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Key event handshake between the PS/2 key decoder (master) and the voice allocator (slave).
interface voice_allocator_if;

  logic                         key_valid;
  logic                         key_ready;
  logic                         key_make;
  logic [synth_pkg::NOTE_W-1:0] key_note;
  logic [synth_pkg::OCT_W-1:0]  key_octave;

  modport master (
    output key_valid,
    output key_make,
    output key_note,
    output key_octave,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_make,
    input  key_note,
    input  key_octave,
    output key_ready
  );

endinterface

// File: rtl/voice_slot.sv
// One voice register: note/octave/gate/age with clear, load, retrigger, release and aging.
module voice_slot
  import synth_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              retrig_i,
  input  logic              release_i,
  input  logic              age_inc_i,
  input  logic [NOTE_W-1:0] note_i,
  input  logic [OCT_W-1:0]  octave_i,
  output voice_t            voice_o
);

  voice_t voice_q, voice_d;

  // Note/octave survive clear and release so the ADSR release tail keeps its pitch.
  always_comb begin
    voice_d = voice_q;
    if (clear_i) begin
      voice_d.gate = 1'b0;
      voice_d.age  = '0;
    end else if (load_i) begin
      voice_d.note   = note_i;
      voice_d.octave = octave_i;
      voice_d.gate   = 1'b1;
      voice_d.age    = '0;
    end else if (retrig_i) begin
      voice_d.age = '0;
    end else if (release_i) begin
      voice_d.gate = 1'b0;
    end else if (age_inc_i && voice_q.gate) begin
      voice_d.age = age_sat_inc(voice_q.age);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      voice_q <= '0;
    end else begin
      voice_q <= voice_d;
    end
  end

  assign voice_o = voice_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: scans all voices per key event, then retriggers, allocates,
// steals the oldest voice, or releases the matching voice.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  voice_allocator_if.slave             key_if,
  input  logic                         all_off,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES*OCT_W-1:0]  voice_octave,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES-1:0]        voice_trigger,
  output logic                         voice_stolen
);

  localparam int unsigned IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_VOICES - 1);

  alloc_state_e      state_q;
  logic [IDX_W-1:0]  idx_q;
  logic              ev_make_q;
  logic [NOTE_W-1:0] ev_note_q;
  logic [OCT_W-1:0]  ev_oct_q;
  logic              match_found_q, free_found_q, old_found_q;
  logic [IDX_W-1:0]  match_idx_q, free_idx_q, old_idx_q;
  logic [AGE_W-1:0]  old_age_q;
  logic              ready_q;
  logic [NUM_VOICES-1:0] trig_q;
  logic              stolen_q;

  voice_t voices [NUM_VOICES];
  voice_t cur;
  logic   cur_match;
  logic   accept;

  logic [NUM_VOICES-1:0] load, retrig, rel, age_inc, trig_d;
  logic                  stolen_d;

  assign accept    = key_if.key_valid && ready_q && !all_off;
  assign cur       = voices[idx_q];
  assign cur_match = cur.gate && (cur.note == ev_note_q) && (cur.octave == ev_oct_q);

  // all_off suppresses the commit so a panic never issues triggers.
  always_comb begin
    load     = '0;
    retrig   = '0;
    rel      = '0;
    age_inc  = '0;
    stolen_d = 1'b0;
    if (state_q == StCommit && !all_off && ev_note_q <= NOTE_W'(NOTE_MAX)) begin
      if (ev_make_q) begin
        if (match_found_q) begin
          retrig[match_idx_q] = 1'b1;
        end else if (free_found_q) begin
          load[free_idx_q] = 1'b1;
        end else begin
          load[old_idx_q] = 1'b1;
          stolen_d        = 1'b1;
        end
        age_inc = ~(load | retrig);
      end else if (match_found_q) begin
        rel[match_idx_q] = 1'b1;
      end
    end
    trig_d = load | retrig;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      ev_make_q     <= 1'b0;
      ev_note_q     <= '0;
      ev_oct_q      <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      ready_q       <= 1'b1;
      trig_q        <= '0;
      stolen_q      <= 1'b0;
    end else begin
      trig_q   <= trig_d;
      stolen_q <= stolen_d;
      // Ready reasserts one cycle after re-entering idle.
      ready_q  <= (state_q == StIdle) && !accept;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            ev_make_q     <= key_if.key_make;
            ev_note_q     <= key_if.key_note;
            ev_oct_q      <= key_if.key_octave;
            match_found_q <= 1'b0;
            free_found_q  <= 1'b0;
            old_found_q   <= 1'b0;
            old_age_q     <= '0;
            idx_q         <= '0;
            state_q       <= StScan;
          end
        end
        StScan: begin
          if (cur_match && !match_found_q) begin
            match_found_q <= 1'b1;
            match_idx_q   <= idx_q;
          end
          if (!cur.gate && !free_found_q) begin
            free_found_q <= 1'b1;
            free_idx_q   <= idx_q;
          end
          // Strict compare keeps the lowest index on an age tie.
          if (cur.gate && (!old_found_q || cur.age > old_age_q)) begin
            old_found_q <= 1'b1;
            old_idx_q   <= idx_q;
            old_age_q   <= cur.age;
          end
          if (idx_q == LastIdx) begin
            state_q <= StCommit;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        StCommit: state_q <= StDone;
        StDone:   state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
      if (all_off) begin
        state_q <= StIdle;
      end
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    voice_slot u_slot (
      .clk_i     (CLOCK_50),
      .rst_i     (reset),
      .clear_i   (all_off),
      .load_i    (load[i]),
      .retrig_i  (retrig[i]),
      .release_i (rel[i]),
      .age_inc_i (age_inc[i]),
      .note_i    (ev_note_q),
      .octave_i  (ev_oct_q),
      .voice_o   (voices[i])
    );
    assign voice_note[i*NOTE_W +: NOTE_W] = voices[i].note;
    assign voice_octave[i*OCT_W +: OCT_W] = voices[i].octave;
    assign voice_gate[i]                  = voices[i].gate;
  end

  assign key_if.key_ready = ready_q;
  assign voice_trigger    = trig_q;
  assign voice_stolen     = stolen_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: allocation, retrigger, stealing, release, panic, reset.
module tb_voice_allocator;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        all_off;
  logic [15:0] voice_note;
  logic [11:0] voice_octave;
  logic [3:0]  voice_gate;
  logic [3:0]  voice_trigger;
  logic        voice_stolen;

  int checks = 0;
  int errors = 0;
  int trig_cnt [4];
  int stolen_cnt = 0;
  int snap [4];
  int snap_stolen;

  voice_allocator_if kif ();

  voice_allocator #(.NUM_VOICES(4)) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .key_if        (kif),
    .all_off       (all_off),
    .voice_note    (voice_note),
    .voice_octave  (voice_octave),
    .voice_gate    (voice_gate),
    .voice_trigger (voice_trigger),
    .voice_stolen  (voice_stolen)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    for (int i = 0; i < 4; i++) begin
      if (voice_trigger[i]) trig_cnt[i]++;
    end
    if (voice_stolen) stolen_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask

  task automatic take_snap();
    for (int i = 0; i < 4; i++) snap[i] = trig_cnt[i];
    snap_stolen = stolen_cnt;
  endtask

  // Returns 1 ns after the accepting edge.
  task automatic send(input logic mk, input logic [3:0] n, input logic [2:0] o);
    int t = 0;
    @(negedge CLOCK_50);
    while (!kif.key_ready && t < 50) begin
      @(negedge CLOCK_50);
      t++;
    end
    if (t >= 50) check("send_timeout", 32'(t), 32'd0);
    kif.key_valid  = 1'b1;
    kif.key_make   = mk;
    kif.key_note   = n;
    kif.key_octave = o;
    @(posedge CLOCK_50);
    #1;
    kif.key_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge CLOCK_50);
    while (!kif.key_ready && t < 50) begin
      @(negedge CLOCK_50);
      t++;
    end
    if (t >= 50) check("idle_timeout", 32'(t), 32'd0);
  endtask

  task automatic press_idle(input logic [3:0] n);
    send(1'b1, n, 3'd3);
    wait_idle();
  endtask

  initial begin
    reset          = 1'b1;
    all_off        = 1'b0;
    kif.key_valid  = 1'b0;
    kif.key_make   = 1'b0;
    kif.key_note   = '0;
    kif.key_octave = '0;
    #12;
    reset = 1'b0;
    @(negedge CLOCK_50);

    // Reset state
    check("rst_ready", 32'(kif.key_ready), 32'd1);
    check("rst_gate", 32'(voice_gate), 32'h0);
    check("rst_note", 32'(voice_note), 32'h0);
    check("rst_oct", 32'(voice_octave), 32'h0);
    check("rst_trig", 32'(voice_trigger), 32'h0);

    // First press: gate appears NUM_VOICES+1 edges after accept, ready after +3
    send(1'b1, 4'd0, 3'd3);
    repeat (4) @(posedge CLOCK_50);
    #1;
    check("lat_gate_early", 32'(voice_gate), 32'h0);
    @(posedge CLOCK_50);
    #1;
    check("lat_gate", 32'(voice_gate), 32'h1);
    check("lat_trig", 32'(voice_trigger), 32'h1);
    check("lat_oct", 32'(voice_octave), 32'h003);
    check("lat_note", 32'(voice_note), 32'h0000);
    @(posedge CLOCK_50);
    #1;
    check("trig_pulse_end", 32'(voice_trigger), 32'h0);
    check("ready_low_6", 32'(kif.key_ready), 32'd0);
    @(posedge CLOCK_50);
    #1;
    check("ready_high_7", 32'(kif.key_ready), 32'd1);

    // Fill all four voices, then steal the oldest
    do_reset();
    press_idle(4'd0);
    press_idle(4'd4);
    press_idle(4'd7);
    press_idle(4'd11);
    check("fill_gate", 32'(voice_gate), 32'hF);
    take_snap();
    press_idle(4'd2);
    check("steal_cnt", 32'(stolen_cnt - snap_stolen), 32'd1);
    check("steal_note", 32'(voice_note), 32'hB742);
    check("steal_oct", 32'(voice_octave), 32'h6DB);
    check("steal_gate", 32'(voice_gate), 32'hF);
    check("steal_trig0", 32'(trig_cnt[0] - snap[0]), 32'd1);
    check("steal_trig3", 32'(trig_cnt[3] - snap[3]), 32'd0);

    // Same note twice: retrigger voice 0 only
    do_reset();
    take_snap();
    press_idle(4'd4);
    press_idle(4'd4);
    check("retrig_gate", 32'(voice_gate), 32'h1);
    check("retrig_note", 32'(voice_note), 32'h0004);
    check("retrig_t0", 32'(trig_cnt[0] - snap[0]), 32'd2);
    check("retrig_t1", 32'(trig_cnt[1] - snap[1]), 32'd0);
    check("retrig_stolen", 32'(stolen_cnt - snap_stolen), 32'd0);

    // Release, release of unheld note, out-of-range note
    do_reset();
    press_idle(4'd0);
    press_idle(4'd4);
    send(1'b0, 4'd4, 3'd3);
    wait_idle();
    check("rel_gate", 32'(voice_gate), 32'h1);
    check("rel_note_kept", 32'(voice_note), 32'h0040);
    send(1'b0, 4'd9, 3'd3);
    wait_idle();
    check("rel_unheld_gate", 32'(voice_gate), 32'h1);
    take_snap();
    press_idle(4'd12);
    check("bad_note_gate", 32'(voice_gate), 32'h1);
    check("bad_note_note", 32'(voice_note), 32'h0040);
    check("bad_note_trig", 32'(trig_cnt[1] - snap[1]), 32'd0);

    // key_valid during SCAN is dropped
    do_reset();
    take_snap();
    send(1'b1, 4'd0, 3'd3);
    @(posedge CLOCK_50);
    #1;
    check("scan_ready", 32'(kif.key_ready), 32'd0);
    kif.key_valid = 1'b1;
    kif.key_note  = 4'd5;
    @(posedge CLOCK_50);
    #1;
    kif.key_valid = 1'b0;
    wait_idle();
    repeat (10) @(negedge CLOCK_50);
    check("drop_gate", 32'(voice_gate), 32'h1);
    check("drop_note", 32'(voice_note), 32'h0000);
    check("drop_t1", 32'(trig_cnt[1] - snap[1]), 32'd0);

    // all_off in the COMMIT cycle of a fourth press
    do_reset();
    press_idle(4'd0);
    press_idle(4'd4);
    press_idle(4'd7);
    take_snap();
    send(1'b1, 4'd9, 3'd3);
    repeat (4) @(posedge CLOCK_50);
    #1;
    all_off = 1'b1;
    @(posedge CLOCK_50);
    #1;
    all_off = 1'b0;
    wait_idle();
    check("panic_gate", 32'(voice_gate), 32'h0);
    check("panic_trig", 32'((trig_cnt[0] - snap[0]) + (trig_cnt[1] - snap[1]) +
                            (trig_cnt[2] - snap[2]) + (trig_cnt[3] - snap[3])), 32'd0);
    check("panic_note", 32'(voice_note), 32'h0740);

    // Asynchronous reset mid-SCAN
    send(1'b1, 4'd0, 3'd3);
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #2;
    reset = 1'b1;
    #1;
    check("arst_ready", 32'(kif.key_ready), 32'd1);
    check("arst_gate", 32'(voice_gate), 32'h0);
    check("arst_note", 32'(voice_note), 32'h0);
    check("arst_oct", 32'(voice_octave), 32'h0);
    check("arst_trig", 32'({voice_stolen, voice_trigger}), 32'h0);
    #2;
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
